// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory responder and its arbiter.
package mem_pkg;

    localparam int MEM_ADDR_W = 12;
    localparam int MEM_DATA_W = 32;

    typedef logic [29:0]           word_addr_t;
    typedef logic [MEM_DATA_W-1:0] word_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_id_t;

endpackage

// File: rtl/mem_arbiter.sv
// Grant logic for the single storage port. Data wins by default; fetch is
// forced through once data has been granted STARVE_MAX times in a row while
// fetch was waiting.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int STARVE_MAX = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     if_valid_i,
    input  logic     d_valid_i,
    output logic     if_grant_o,
    output logic     d_grant_o,
    output logic     gnt_valid_o,
    output port_id_t gnt_port_o
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             force_if;

    // Grant decision and starvation counter next state.
    always_comb begin
        force_if    = if_valid_i && d_valid_i && (cnt_q == CNT_MAX);
        d_grant_o   = d_valid_i && !force_if;
        if_grant_o  = if_valid_i && !d_grant_o;
        gnt_valid_o = d_grant_o || if_grant_o;
        gnt_port_o  = d_grant_o ? PORT_D : PORT_IF;
        cnt_d       = cnt_q;
        if (!if_valid_i || if_grant_o) begin
            cnt_d = '0;
        end else if (d_grant_o && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Single-port word SRAM responder for the fetch and data initiators.
// Both request channels are arbitrated onto one storage port; read data is
// registered and returned one cycle after grant.
// Optional feature: define MEM_BYTE_WRITE_EN to add per-byte store enables.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int STARVE_MAX = 2
) (
    input  logic              mem_clk,
    input  logic              reset,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [29:0]       if_addr,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [29:0]       d_addr,
    input  logic              d_wren,
    input  logic [DATA_W-1:0] d_wdata,
`ifdef MEM_BYTE_WRITE_EN
    input  logic [DATA_W/8-1:0] d_be,
`endif
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_data
);

    logic              gnt_valid;
    port_id_t          gnt_port;
    word_addr_t        sel_addr;
    logic [ADDR_W-1:0] idx;
    logic              in_range;
    logic              wr_en;
    logic [DATA_W-1:0] rd_word;

    logic              if_rsp_valid_q, if_rsp_valid_d;
    logic              d_rsp_valid_q,  d_rsp_valid_d;
    logic [DATA_W-1:0] if_rsp_data_q,  if_rsp_data_d;
    logic [DATA_W-1:0] d_rsp_data_q,   d_rsp_data_d;

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    mem_arbiter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk_i       (mem_clk),
        .rst_i       (reset),
        .if_valid_i  (if_req_valid),
        .d_valid_i   (d_req_valid),
        .if_grant_o  (if_req_ready),
        .d_grant_o   (d_req_ready),
        .gnt_valid_o (gnt_valid),
        .gnt_port_o  (gnt_port)
    );

    // Storage port address mux, decode and next response state.
    always_comb begin
        sel_addr = (gnt_port == PORT_D) ? d_addr : if_addr;
        idx      = sel_addr[ADDR_W-1:0];
        in_range = (sel_addr[29:ADDR_W] == '0);
        rd_word  = in_range ? mem_q[idx] : '0;
        wr_en    = gnt_valid && (gnt_port == PORT_D) && d_wren && in_range;

        if_rsp_valid_d = gnt_valid && (gnt_port == PORT_IF);
        d_rsp_valid_d  = gnt_valid && (gnt_port == PORT_D) && !d_wren;
        if_rsp_data_d  = if_rsp_valid_d ? rd_word : if_rsp_data_q;
        d_rsp_data_d   = d_rsp_valid_d  ? rd_word : d_rsp_data_q;
    end

    // Storage write: stores land at the grant edge; out-of-range stores drop.
    always_ff @(posedge mem_clk) begin
        if (wr_en) begin
`ifdef MEM_BYTE_WRITE_EN
            for (int b = 0; b < DATA_W/8; b++) begin
                if (d_be[b]) begin
                    mem_q[idx][b*8 +: 8] <= d_wdata[b*8 +: 8];
                end
            end
`else
            mem_q[idx] <= d_wdata;
`endif
        end
    end

    // Response registers; data holds while valid is low.
    always_ff @(posedge mem_clk or posedge reset) begin
        if (reset) begin
            if_rsp_valid_q <= 1'b0;
            d_rsp_valid_q  <= 1'b0;
            if_rsp_data_q  <= '0;
            d_rsp_data_q   <= '0;
        end else begin
            if_rsp_valid_q <= if_rsp_valid_d;
            d_rsp_valid_q  <= d_rsp_valid_d;
            if_rsp_data_q  <= if_rsp_data_d;
            d_rsp_data_q   <= d_rsp_data_d;
        end
    end

    assign if_rsp_valid = if_rsp_valid_q;
    assign if_rsp_data  = if_rsp_data_q;
    assign d_rsp_valid  = d_rsp_valid_q;
    assign d_rsp_data   = d_rsp_data_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (ADDR_W=12, DATA_W=32, STARVE_MAX=2).
module tb_mem_responder;
    import mem_pkg::*;

    logic        mem_clk = 1'b0;
    logic        reset;
    logic        if_req_valid, if_req_ready, if_rsp_valid;
    logic [29:0] if_addr;
    logic [31:0] if_rsp_data;
    logic        d_req_valid, d_req_ready, d_wren, d_rsp_valid;
    logic [29:0] d_addr;
    logic [31:0] d_wdata, d_rsp_data;
`ifdef MEM_BYTE_WRITE_EN
    logic [3:0]  d_be;
`endif

    int total = 0;
    int bad   = 0;

    always #5 mem_clk = ~mem_clk;

    mem_responder #(.ADDR_W(12), .DATA_W(32), .STARVE_MAX(2)) dut (
        .mem_clk      (mem_clk),
        .reset        (reset),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_addr      (if_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .d_req_valid  (d_req_valid),
        .d_req_ready  (d_req_ready),
        .d_addr       (d_addr),
        .d_wren       (d_wren),
        .d_wdata      (d_wdata),
`ifdef MEM_BYTE_WRITE_EN
        .d_be         (d_be),
`endif
        .d_rsp_valid  (d_rsp_valid),
        .d_rsp_data   (d_rsp_data)
    );

    typedef struct {
        logic        ifv;
        logic [29:0] ifa;
        logic        dv;
        logic [29:0] da;
        logic        we;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        e_ifr, e_dr;   // expected readies in the request cycle
        logic        e_ifv, e_dv;   // expected response valids after the edge
        logic [31:0] e_ifd, e_dd;   // expected response data
        logic        ckd;           // check data even when valid is low
    } vec_t;

    vec_t v [32];
    int   nv;

    function automatic vec_t mk(logic ifv, logic [29:0] ifa, logic dv, logic [29:0] da,
                                logic we, logic [31:0] wd, logic e_ifr, logic e_dr,
                                logic e_ifv, logic e_dv, logic [31:0] e_ifd,
                                logic [31:0] e_dd, logic ckd);
        vec_t r;
        r.ifv = ifv; r.ifa = ifa; r.dv = dv; r.da = da; r.we = we; r.wd = wd;
        r.be = 4'hF; r.e_ifr = e_ifr; r.e_dr = e_dr; r.e_ifv = e_ifv; r.e_dv = e_dv;
        r.e_ifd = e_ifd; r.e_dd = e_dd; r.ckd = ckd;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        if_req_valid = x.ifv;
        if_addr      = x.ifa;
        d_req_valid  = x.dv;
        d_addr       = x.da;
        d_wren       = x.we;
        d_wdata      = x.wd;
`ifdef MEM_BYTE_WRITE_EN
        d_be         = x.be;
`endif
    endtask

    task automatic idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    // One request cycle: check readies before the edge, responses after it.
    task automatic run_vec(input vec_t x, input string nm);
        drive(x);
        #1;
        chk({nm, " if_ready"}, 32'(if_req_ready), 32'(x.e_ifr));
        chk({nm, " d_ready"},  32'(d_req_ready),  32'(x.e_dr));
        @(posedge mem_clk); #1;
        chk({nm, " if_rsp_valid"}, 32'(if_rsp_valid), 32'(x.e_ifv));
        chk({nm, " d_rsp_valid"},  32'(d_rsp_valid),  32'(x.e_dv));
        if (x.e_ifv || x.ckd) chk({nm, " if_rsp_data"}, if_rsp_data, x.e_ifd);
        if (x.e_dv  || x.ckd) chk({nm, " d_rsp_data"},  d_rsp_data,  x.e_dd);
    endtask

    initial begin
        vec_t bv;

        // ---- vector table ----
        v[0]  = mk(0, 0,     1, 'h10,   1, 'hDEADBEEF, 0, 1, 0, 0, 0, 0, 0);
        v[1]  = mk(0, 0,     1, 'h10,   0, 0,          0, 1, 0, 1, 0, 'hDEADBEEF, 0);
        for (int i = 0; i < 4; i++)
            v[2+i] = mk(0, 0, 1, 30'(i), 1, 32'hC0DE0000 + 32'(i), 0, 1, 0, 0, 0, 0, 0);
        v[6]  = mk(0, 0,     1, 'h20,   1, 'h12345678, 0, 1, 0, 0, 0, 0, 0);
        // contention: D, D, IF, D
        v[7]  = mk(1, 'h20,  1, 'h10,   0, 0,          0, 1, 0, 1, 0, 'hDEADBEEF, 0);
        v[8]  = v[7];
        v[9]  = mk(1, 'h20,  1, 'h10,   0, 0,          1, 0, 1, 0, 'h12345678, 0, 0);
        v[10] = v[7];
        // back-to-back fetches
        for (int i = 0; i < 4; i++)
            v[11+i] = mk(1, 30'(i), 0, 0, 0, 0, 1, 0, 1, 0, 32'hC0DE0000 + 32'(i), 0, 0);
        // idle: no readies, data holds
        v[15] = mk(0, 0,     0, 0,      0, 0,          0, 0, 0, 0, 'hC0DE0003, 'hDEADBEEF, 1);
        // out-of-range load / store
        v[16] = mk(0, 0,     1, 'h1000, 0, 0,          0, 1, 0, 1, 0, 0, 0);
        v[17] = mk(0, 0,     1, 'h1000, 1, 'hFFFFFFFF, 0, 1, 0, 0, 0, 0, 0);
        v[18] = mk(0, 0,     1, 0,      0, 0,          0, 1, 0, 1, 0, 'hC0DE0000, 0);
        // read-after-write
        v[19] = mk(0, 0,     1, 'h30,   1, 'h55AA55AA, 0, 1, 0, 0, 0, 0, 0);
        v[20] = mk(0, 0,     1, 'h30,   0, 0,          0, 1, 0, 1, 0, 'h55AA55AA, 0);
        // fetch dropping its valid clears the counter
        v[21] = mk(1, 'h20,  1, 'h30,   0, 0,          0, 1, 0, 1, 0, 'h55AA55AA, 0);
        v[22] = v[21];
        v[23] = mk(0, 0,     1, 'h30,   0, 0,          0, 1, 0, 1, 0, 'h55AA55AA, 0);
        v[24] = v[21];
        v[25] = v[21];
        v[26] = mk(1, 'h20,  1, 'h30,   0, 0,          1, 0, 1, 0, 'h12345678, 0, 0);
        nv = 27;

        // ---- reset state ----
        reset = 1'b1;
        idle();
        @(posedge mem_clk); #1;
        chk("rst if_rsp_valid", 32'(if_rsp_valid), 0);
        chk("rst d_rsp_valid",  32'(d_rsp_valid),  0);
        chk("rst if_rsp_data",  if_rsp_data, 0);
        chk("rst d_rsp_data",   d_rsp_data,  0);
        reset = 1'b0;

        for (int i = 0; i < nv; i++) run_vec(v[i], $sformatf("v%0d", i));

        // ---- async reset right after a load grant ----
        drive(mk(0, 0, 1, 'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge mem_clk); #1;
        chk("pre-rst d_rsp_valid", 32'(d_rsp_valid), 1);
        idle();
        reset = 1'b1;
        #1;
        chk("async rst d_rsp_valid", 32'(d_rsp_valid), 0);
        chk("async rst d_rsp_data",  d_rsp_data, 0);
        chk("async rst if_rsp_data", if_rsp_data, 0);
        @(posedge mem_clk); #1;
        reset = 1'b0;

        // ---- reset across the grant edge suppresses the response ----
        drive(mk(0, 0, 1, 'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        reset = 1'b1;
        @(posedge mem_clk); #1;
        chk("rst-at-grant d_rsp_valid", 32'(d_rsp_valid), 0);
        idle();
        reset = 1'b0;
        @(posedge mem_clk); #1;
        chk("after rst d_rsp_valid", 32'(d_rsp_valid), 0);

        // ---- reset clears the starvation counter ----
        drive(mk(1, 'h20, 1, 'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge mem_clk); #1;
        @(posedge mem_clk); #1;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        chk("cnt rst d_ready",  32'(d_req_ready),  1);
        chk("cnt rst if_ready", 32'(if_req_ready), 0);
        idle();
        @(posedge mem_clk); #1;

`ifdef MEM_BYTE_WRITE_EN
        // ---- byte enables ----
        run_vec(mk(0, 0, 1, 'h40, 1, 'h11223344, 0, 1, 0, 0, 0, 0, 0), "be full");
        bv = mk(0, 0, 1, 'h40, 1, 'hAABBCCDD, 0, 1, 0, 0, 0, 0, 0);
        bv.be = 4'b0101;
        run_vec(bv, "be 0101");
        bv = mk(0, 0, 1, 'h40, 0, 0, 0, 1, 0, 1, 0, 'h11BB33DD, 0);
        bv.be = 4'b0000;
        run_vec(bv, "be readback");
        bv = mk(0, 0, 1, 'h40, 1, 'hFFFFFFFF, 0, 1, 0, 0, 0, 0, 0);
        bv.be = 4'b0000;
        run_vec(bv, "be none");
        run_vec(mk(0, 0, 1, 'h40, 0, 0, 0, 1, 0, 1, 0, 'h11BB33DD, 0), "be none readback");
`else
        bv = mk(0, 0, 1, 'h40, 1, 'h11223344, 0, 1, 0, 0, 0, 0, 0);
        run_vec(bv, "word store");
        run_vec(mk(0, 0, 1, 'h40, 0, 0, 0, 1, 0, 1, 0, 'h11223344, 0), "word readback");
`endif

        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
